// File: rtl/icache_refill_responder.sv
// I$ refill responder: fetches a line beat by beat from a narrow memory port and returns it in
// one grant pulse; forwards invalidations ordered after a same-line fill. Option macro:
// ICACHE_REFILL_SWAP_ENDIAN_EN byte-reverses each beat before it enters the line.
module icache_refill_responder #(
  parameter int unsigned PAddrWidth = 40,
  parameter int unsigned LineWidth  = 256,
  parameter int unsigned BeatWidth  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [PAddrWidth-1:0] req_paddr_i,
  output logic                  resp_valid_o,
  output logic [LineWidth-1:0]  resp_data_o,
  input  logic                  inval_req_valid_i,
  output logic                  inval_req_ready_o,
  input  logic [PAddrWidth-1:0] inval_req_addr_i,
  output logic                  inval_valid_o,
  output logic [PAddrWidth-1:0] inval_addr_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PAddrWidth-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [BeatWidth-1:0]  mem_rsp_data_i,
  output logic                  err_o
);

  localparam int unsigned NBeats    = LineWidth / BeatWidth;
  localparam int unsigned BeatCntW  = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam int unsigned OffW      = $clog2(LineWidth / 8);
  localparam int unsigned BeatBytes = BeatWidth / 8;
  localparam logic [BeatCntW-1:0]   LastBeat = BeatCntW'(NBeats - 1);
  localparam logic [PAddrWidth-1:0] OffMask  = PAddrWidth'((64'd1 << OffW) - 64'd1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                  state_q;
  logic [BeatCntW-1:0]     beat_q;
  logic [PAddrWidth-1:0]   line_addr_q;
  logic [LineWidth-1:0]    line_q;
  logic                    req_ready_q;
  logic                    mem_req_valid_q;
  logic [PAddrWidth-1:0]   mem_req_addr_q;
  logic                    resp_valid_q;
  logic                    err_q;
  logic                    inval_valid_q;
  logic                    inval_held_q;
  logic [PAddrWidth-1:0]   inval_addr_q;

  logic [BeatWidth-1:0]    beat_data;
  logic [BeatCntW-1:0]     beat_nxt;
  logic [PAddrWidth-1:0]   beat_nxt_addr;
  logic                    enter_resp;
  logic                    inval_same_line;
  logic                    inval_fire;

  always_comb begin
`ifdef ICACHE_REFILL_SWAP_ENDIAN_EN
    beat_data = '0;
    for (int i = 0; i < int'(BeatBytes); i++) begin
      beat_data[8*i +: 8] = mem_rsp_data_i[BeatWidth - 8 - 8*i +: 8];
    end
`else
    beat_data = mem_rsp_data_i;
`endif
  end

  assign beat_nxt      = beat_q + BeatCntW'(1);
  assign beat_nxt_addr = line_addr_q + PAddrWidth'(beat_nxt) * PAddrWidth'(BeatBytes);
  assign enter_resp    = (state_q == StWait) && mem_rsp_valid_i && (beat_q == LastBeat);

  // Same-line invalidations wait until the fill has been delivered.
  assign inval_same_line   = (state_q != StIdle) &&
                             ((inval_req_addr_i & ~OffMask) == line_addr_q);
  assign inval_req_ready_o = !inval_held_q && !inval_same_line;
  assign inval_fire        = inval_req_valid_i && inval_req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      beat_q          <= '0;
      line_addr_q     <= '0;
      line_q          <= '0;
      req_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      resp_valid_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      if (mem_rsp_valid_i && (state_q != StWait)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q     <= 1'b0;
            line_addr_q     <= req_paddr_i & ~OffMask;
            beat_q          <= '0;
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= req_paddr_i & ~OffMask;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= StWait;
          end
        end
        StWait: begin
          if (mem_rsp_valid_i) begin
            for (int b = 0; b < int'(NBeats); b++) begin
              if (beat_q == BeatCntW'(b)) line_q[b*BeatWidth +: BeatWidth] <= beat_data;
            end
            if (beat_q == LastBeat) begin
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              beat_q          <= beat_nxt;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= beat_nxt_addr;
              state_q         <= StIssue;
            end
          end
        end
        StResp: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // An invalidation accepted just before a RESP cycle is held one extra cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inval_valid_q <= 1'b0;
      inval_held_q  <= 1'b0;
      inval_addr_q  <= '0;
    end else begin
      inval_valid_q <= 1'b0;
      if (inval_held_q) begin
        inval_held_q  <= 1'b0;
        inval_valid_q <= 1'b1;
      end
      if (inval_fire) begin
        inval_addr_q <= inval_req_addr_i & ~OffMask;
        if (enter_resp) inval_held_q  <= 1'b1;
        else            inval_valid_q <= 1'b1;
      end
    end
  end

  assign req_ready_o     = req_ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = line_q;
  assign inval_valid_o   = inval_valid_q;
  assign inval_addr_o    = inval_addr_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign err_o           = err_q;

endmodule
